// File: rtl/chinpo_mem_arbiter_if.sv
// Bus bundle between the CHINPO CPU port, the DMA/loader port and the memory macro.
// Both requesters use req/ack: req, we, addr and wdata stay stable from req rise through the ack cycle.
interface chinpo_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        owner;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner
  );

  // Requester/memory environment side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner
  );
endinterface

// File: rtl/chinpo_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the CPU and a DMA port.
// Each access is ISSUE (strobe memory) then DONE (ack, read data); contention alternates masters.
module chinpo_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                 CLK,
  input  logic                 Reset,
  chinpo_mem_arbiter_if.slave  bus,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CPU_ISSUE = 3'd1,
    CPU_DONE  = 3'd2,
    DMA_ISSUE = 3'd3,
    DMA_DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              last_dma;   // 1 = DMA was granted most recently
  logic [DATA_W-1:0] cpu_hold;
  logic [DATA_W-1:0] dma_hold;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              cpu_ack_c;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= IDLE;
      last_dma <= 1'b1;
      cpu_hold <= '0;
      dma_hold <= '0;
    end else begin
      state <= next_state;
      if (state == CPU_ISSUE) last_dma <= 1'b0;
      if (state == DMA_ISSUE) last_dma <= 1'b1;
      if (state == CPU_DONE && !bus.cpu_we) cpu_hold <= bus.mem_rdata;
      if (state == DMA_DONE && !bus.dma_we) dma_hold <= bus.mem_rdata;
    end
  end

  // The served master's own req is ignored in DONE: it still shows the finished request.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.cpu_req && bus.dma_req) next_state = last_dma ? CPU_ISSUE : DMA_ISSUE;
        else if (bus.cpu_req)           next_state = CPU_ISSUE;
        else if (bus.dma_req)           next_state = DMA_ISSUE;
        else                            next_state = IDLE;
      end
      CPU_ISSUE: next_state = CPU_DONE;
      CPU_DONE:  next_state = bus.dma_req ? DMA_ISSUE : IDLE;
      DMA_ISSUE: next_state = DMA_DONE;
      DMA_DONE:  next_state = bus.cpu_req ? CPU_ISSUE : IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    addr_sel      = bus.cpu_addr;
    wdata_sel     = bus.cpu_wdata;
    cpu_ack_c     = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.cpu_ack   = 1'b0;
    bus.dma_ack   = 1'b0;
    bus.cpu_rdata = cpu_hold;
    bus.dma_rdata = dma_hold;
    bus.owner     = 2'b00;
    case (state)
      CPU_ISSUE: begin
        bus.mem_en = 1'b1;
        bus.mem_we = bus.cpu_we;
        bus.owner  = 2'b01;
      end
      CPU_DONE: begin
        cpu_ack_c   = 1'b1;
        bus.cpu_ack = 1'b1;
        bus.owner   = 2'b01;
        if (!bus.cpu_we) bus.cpu_rdata = bus.mem_rdata;
      end
      DMA_ISSUE: begin
        bus.mem_en = 1'b1;
        bus.mem_we = bus.dma_we;
        bus.owner  = 2'b10;
        addr_sel   = bus.dma_addr;
        wdata_sel  = bus.dma_wdata;
      end
      DMA_DONE: begin
        bus.dma_ack = 1'b1;
        bus.owner   = 2'b10;
        if (!bus.dma_we) bus.dma_rdata = bus.mem_rdata;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;
  assign bus.cpu_stall = bus.cpu_req && !cpu_ack_c;
  assign state_dbg     = state;

endmodule

// File: tb/tb_chinpo_mem_arbiter.sv
// Bench for chinpo_mem_arbiter: directed scenarios plus a randomized two-master run
// scored against an access-ordered reference memory.
module tb_chinpo_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [2:0] state_dbg;
  int         n_cmp = 0;
  int         n_bad = 0;

  chinpo_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  chinpo_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // ---------------- memory macro model ----------------
  logic [DATA_W-1:0] mem [0:1023];
  logic              bd_en;
  logic [9:0]        bd_addr;
  logic [DATA_W-1:0] bd_data;

  always @(posedge CLK) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[9:0]];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic bd_write(input logic [9:0] a, input logic [DATA_W-1:0] d);
    bd_en = 1'b1; bd_addr = a; bd_data = d;
    step();
    bd_en = 1'b0;
  endtask

  task automatic cpu_set(input logic r, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.cpu_req = r; bus.cpu_we = w; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic dma_set(input logic r, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.dma_req = r; bus.dma_we = w; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset = 1'b1;
    cpu_set(1'b1, 1'b0, 16'h0010, 16'h0000);
    dma_set(1'b1, 1'b0, 16'h0020, 16'h0000);
    bd_write(10'h010, 16'hBEEF);
    bd_write(10'h020, 16'h0BAD);
    for (int i = 0; i < 8; i++) bd_write(10'h100 + 10'(i), 16'h0000);
    step(); step();
    n_cmp++; if (bus.owner !== 2'b00) begin n_bad++; $display("FAIL reset_owner: got %b want 00", bus.owner); end
    n_cmp++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL reset_mem_en: got %b want 0", bus.mem_en); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    n_cmp++; if (bus.cpu_rdata !== 16'h0) begin n_bad++; $display("FAIL reset_cpu_rdata: got %h want 0000", bus.cpu_rdata); end
    n_cmp++; if (bus.dma_rdata !== 16'h0) begin n_bad++; $display("FAIL reset_dma_rdata: got %h want 0000", bus.dma_rdata); end
    n_cmp++; if (bus.cpu_ack !== 1'b0 || bus.dma_ack !== 1'b0) begin n_bad++; $display("FAIL reset_acks: got %b%b want 00", bus.cpu_ack, bus.dma_ack); end
    n_cmp++; if (bus.cpu_stall !== 1'b1) begin n_bad++; $display("FAIL reset_stall: got %b want 1", bus.cpu_stall); end
    Reset = 1'b0;
    step();
    n_cmp++; if (bus.owner !== 2'b01) begin n_bad++; $display("FAIL reset_first_grant: got %b want 01", bus.owner); end
    step();
    n_cmp++; if (bus.cpu_ack !== 1'b1) begin n_bad++; $display("FAIL reset_first_cpu_ack: got %b want 1", bus.cpu_ack); end
    step();
    bus.cpu_req = 1'b0;
    n_cmp++; if (bus.owner !== 2'b10) begin n_bad++; $display("FAIL reset_second_grant: got %b want 10", bus.owner); end
    step();
    n_cmp++; if (bus.dma_ack !== 1'b1 || bus.dma_rdata !== 16'h0BAD) begin n_bad++; $display("FAIL reset_dma_done: got ack %b data %h want 1 0bad", bus.dma_ack, bus.dma_rdata); end
    step();
    bus.dma_req = 1'b0;
    step();
  endtask

  task automatic test_cpu_read();
    cpu_set(1'b1, 1'b0, 16'h0010, 16'h5555);
    #1;
    n_cmp++; if (bus.cpu_stall !== 1'b1) begin n_bad++; $display("FAIL cpurd_stall_req: got %b want 1", bus.cpu_stall); end
    step();
    n_cmp++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0010) begin n_bad++; $display("FAIL cpurd_issue: got en %b we %b addr %h want 1 0 0010", bus.mem_en, bus.mem_we, bus.mem_addr); end
    n_cmp++; if (bus.cpu_ack !== 1'b0 || bus.cpu_stall !== 1'b1) begin n_bad++; $display("FAIL cpurd_issue_ack: got ack %b stall %b want 0 1", bus.cpu_ack, bus.cpu_stall); end
    step();
    n_cmp++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 16'hBEEF || bus.cpu_stall !== 1'b0) begin n_bad++; $display("FAIL cpurd_done: got ack %b data %h stall %b want 1 beef 0", bus.cpu_ack, bus.cpu_rdata, bus.cpu_stall); end
    n_cmp++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL cpurd_done_en: got %b want 0", bus.mem_en); end
    step();
    bus.cpu_req = 1'b0;
    n_cmp++; if (bus.cpu_ack !== 1'b0 || bus.owner !== 2'b00) begin n_bad++; $display("FAIL cpurd_after: got ack %b owner %b want 0 00", bus.cpu_ack, bus.owner); end
    step();
    n_cmp++; if (bus.cpu_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL cpurd_hold: got %h want beef", bus.cpu_rdata); end
  endtask

  task automatic test_dma_write_cpu_read();
    dma_set(1'b1, 1'b1, 16'h0020, 16'h1234);
    step();
    n_cmp++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0020 || bus.mem_wdata !== 16'h1234 || bus.owner !== 2'b10) begin
      n_bad++; $display("FAIL dmawr_issue: got en %b we %b addr %h wd %h owner %b want 1 1 0020 1234 10", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.owner); end
    step();
    n_cmp++; if (bus.dma_ack !== 1'b1 || bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL dmawr_done: got ack %b we %b want 1 0", bus.dma_ack, bus.mem_we); end
    n_cmp++; if (bus.dma_rdata !== 16'h0BAD) begin n_bad++; $display("FAIL dmawr_rdata_hold: got %h want 0bad", bus.dma_rdata); end
    step();
    bus.dma_req = 1'b0;
    cpu_set(1'b1, 1'b0, 16'h0020, 16'h0000);
    step();
    n_cmp++; if (bus.mem_we !== 1'b0 || bus.owner !== 2'b01) begin n_bad++; $display("FAIL dmawr_cpu_issue: got we %b owner %b want 0 01", bus.mem_we, bus.owner); end
    step();
    n_cmp++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 16'h1234) begin n_bad++; $display("FAIL dmawr_cpu_read: got ack %b data %h want 1 1234", bus.cpu_ack, bus.cpu_rdata); end
    step();
    bus.cpu_req = 1'b0;
    step();
  endtask

  task automatic test_contention();
    logic [1:0] exp_q[$];
    logic [1:0] exp_owner;
    logic [1:0] got;
    int         acks;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    cpu_set(1'b1, 1'b0, 16'h0010, 16'h0000);
    dma_set(1'b1, 1'b0, 16'h0020, 16'h0000);
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    acks = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k % 2 == 1) begin
        exp_owner = (k % 4 == 1) ? 2'b01 : 2'b10;
        n_cmp++; if (bus.mem_en !== 1'b1 || bus.owner !== exp_owner) begin n_bad++; $display("FAIL cont_issue_%0d: got en %b owner %b want 1 %b", k, bus.mem_en, bus.owner, exp_owner); end
      end
      if (bus.cpu_ack || bus.dma_ack) begin
        acks++;
        got = {bus.dma_ack, bus.cpu_ack};
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL cont_extra_ack_%0d: got %b want none", k, got);
        end else begin
          exp_owner = exp_q.pop_front();
          n_cmp++; if (got !== exp_owner) begin n_bad++; $display("FAIL cont_ack_order_%0d: got %b want %b", k, got, exp_owner); end
          if (bus.cpu_ack) begin
            n_cmp++; if (bus.cpu_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL cont_cpu_data_%0d: got %h want beef", k, bus.cpu_rdata); end
          end else begin
            n_cmp++; if (bus.dma_rdata !== 16'h1234) begin n_bad++; $display("FAIL cont_dma_data_%0d: got %h want 1234", k, bus.dma_rdata); end
          end
        end
      end
    end
    n_cmp++; if (acks !== 5) begin n_bad++; $display("FAIL cont_ack_count: got %0d want 5", acks); end
    step();
    bus.cpu_req = 1'b0;
    step();
    n_cmp++; if (bus.dma_ack !== 1'b1) begin n_bad++; $display("FAIL cont_drain_dma_ack: got %b want 1", bus.dma_ack); end
    step();
    bus.dma_req = 1'b0;
    n_cmp++; if (bus.owner !== 2'b00) begin n_bad++; $display("FAIL cont_drain_idle: got %b want 00", bus.owner); end
    step();
  endtask

  task automatic test_reset_mid();
    cpu_set(1'b1, 1'b0, 16'h0010, 16'h0000);
    step();
    n_cmp++; if (bus.owner !== 2'b01 || bus.mem_en !== 1'b1) begin n_bad++; $display("FAIL rstmid_issue: got owner %b en %b want 01 1", bus.owner, bus.mem_en); end
    Reset = 1'b1;
    step();
    n_cmp++; if (bus.cpu_ack !== 1'b0 || bus.owner !== 2'b00 || bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_abort: got ack %b owner %b en %b want 0 00 0", bus.cpu_ack, bus.owner, bus.mem_en); end
    n_cmp++; if (bus.cpu_rdata !== 16'h0 || bus.dma_rdata !== 16'h0) begin n_bad++; $display("FAIL rstmid_rdata: got %h %h want 0000 0000", bus.cpu_rdata, bus.dma_rdata); end
    Reset = 1'b0;
    step();
    n_cmp++; if (bus.owner !== 2'b01 || bus.mem_en !== 1'b1) begin n_bad++; $display("FAIL rstmid_rereq_issue: got owner %b en %b want 01 1", bus.owner, bus.mem_en); end
    step();
    n_cmp++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL rstmid_rereq_done: got ack %b data %h want 1 beef", bus.cpu_ack, bus.cpu_rdata); end
    step();
    bus.cpu_req = 1'b0;
    step();
  endtask

  task automatic test_early_drop();
    int acks;
    dma_set(1'b1, 1'b0, 16'h0020, 16'h0000);
    step();
    bus.dma_req = 1'b0;
    n_cmp++; if (bus.owner !== 2'b10) begin n_bad++; $display("FAIL drop_issue: got owner %b want 10", bus.owner); end
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.dma_ack) begin
        acks++;
        n_cmp++; if (bus.dma_rdata !== 16'h1234) begin n_bad++; $display("FAIL drop_data: got %h want 1234", bus.dma_rdata); end
      end
    end
    n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL drop_ack_count: got %0d want 1", acks); end
    n_cmp++; if (bus.owner !== 2'b00) begin n_bad++; $display("FAIL drop_idle: got %b want 00", bus.owner); end
  endtask

  // Two independent requesters; the reference memory is updated in ack order,
  // which is the order the single-port memory actually serves accesses.
  task automatic test_random();
    logic [DATA_W-1:0] ref_mem [0:7];
    logic [DATA_W-1:0] exp_c_hold, exp_d_hold;
    int                c_st, d_st, c_lat, d_lat;
    logic              c_we, d_we;
    logic [2:0]        c_ix, d_ix;
    logic [DATA_W-1:0] c_wd, d_wd;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = DATA_W'($urandom);
      bd_write(10'h100 + 10'(i), ref_mem[i]);
    end
    exp_c_hold = 16'hBEEF;
    exp_d_hold = 16'h1234;
    c_st = 0; d_st = 0; c_lat = 0; d_lat = 0;
    c_we = 0; d_we = 0; c_ix = 0; d_ix = 0; c_wd = 0; d_wd = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      if (c_st == 1) c_lat++;
      if (d_st == 1) d_lat++;
      n_cmp++; if (bus.cpu_stall !== (bus.cpu_req && !bus.cpu_ack)) begin n_bad++; $display("FAIL rnd_stall_%0d: got %b req %b ack %b", cyc, bus.cpu_stall, bus.cpu_req, bus.cpu_ack); end
      n_cmp++; if (bus.cpu_ack && bus.dma_ack) begin n_bad++; $display("FAIL rnd_dual_ack_%0d: got 11 want at most one", cyc); end
      if (bus.cpu_ack) begin
        n_cmp++;
        if (c_st != 1) begin n_bad++; $display("FAIL rnd_cpu_spurious_%0d: got ack with no request", cyc); end
        else if (c_lat < 2 || c_lat > 4) begin n_bad++; $display("FAIL rnd_cpu_latency_%0d: got %0d want 2..4", cyc, c_lat); end
        else if (!c_we && bus.cpu_rdata !== ref_mem[c_ix]) begin n_bad++; $display("FAIL rnd_cpu_rd_%0d: got %h want %h", cyc, bus.cpu_rdata, ref_mem[c_ix]); end
        else if (c_we && bus.cpu_rdata !== exp_c_hold) begin n_bad++; $display("FAIL rnd_cpu_wr_hold_%0d: got %h want %h", cyc, bus.cpu_rdata, exp_c_hold); end
        if (c_we) ref_mem[c_ix] = c_wd;
        else      exp_c_hold = ref_mem[c_ix];
        c_st = 3;
      end else begin
        n_cmp++; if (bus.cpu_rdata !== exp_c_hold) begin n_bad++; $display("FAIL rnd_cpu_hold_%0d: got %h want %h", cyc, bus.cpu_rdata, exp_c_hold); end
      end
      if (bus.dma_ack) begin
        n_cmp++;
        if (d_st != 1) begin n_bad++; $display("FAIL rnd_dma_spurious_%0d: got ack with no request", cyc); end
        else if (d_lat < 2 || d_lat > 4) begin n_bad++; $display("FAIL rnd_dma_latency_%0d: got %0d want 2..4", cyc, d_lat); end
        else if (!d_we && bus.dma_rdata !== ref_mem[d_ix]) begin n_bad++; $display("FAIL rnd_dma_rd_%0d: got %h want %h", cyc, bus.dma_rdata, ref_mem[d_ix]); end
        else if (d_we && bus.dma_rdata !== exp_d_hold) begin n_bad++; $display("FAIL rnd_dma_wr_hold_%0d: got %h want %h", cyc, bus.dma_rdata, exp_d_hold); end
        if (d_we) ref_mem[d_ix] = d_wd;
        else      exp_d_hold = ref_mem[d_ix];
        d_st = 3;
      end else begin
        n_cmp++; if (bus.dma_rdata !== exp_d_hold) begin n_bad++; $display("FAIL rnd_dma_hold_%0d: got %h want %h", cyc, bus.dma_rdata, exp_d_hold); end
      end
      if (c_st == 1 && c_lat > 6) begin n_cmp++; n_bad++; $display("FAIL rnd_cpu_timeout_%0d: got no ack in %0d cycles", cyc, c_lat); c_st = 2; end
      if (d_st == 1 && d_lat > 6) begin n_cmp++; n_bad++; $display("FAIL rnd_dma_timeout_%0d: got no ack in %0d cycles", cyc, d_lat); d_st = 2; end
      // drive: 3 = ack cycle (hold), 2 = cycle after ack (drop or re-request), 0 = free
      if (c_st == 3) c_st = 2;
      else if ((c_st == 2 && $urandom_range(0, 1) == 1) || (c_st == 0 && $urandom_range(0, 2) == 0)) begin
        c_we = 1'($urandom); c_ix = 3'($urandom); c_wd = DATA_W'($urandom);
        cpu_set(1'b1, c_we, 16'h0100 + 16'(c_ix), c_wd);
        c_st = 1; c_lat = 0;
      end else if (c_st == 2) begin
        bus.cpu_req = 1'b0; c_st = 0;
      end
      if (d_st == 3) d_st = 2;
      else if ((d_st == 2 && $urandom_range(0, 1) == 1) || (d_st == 0 && $urandom_range(0, 2) == 0)) begin
        d_we = 1'($urandom); d_ix = 3'($urandom); d_wd = DATA_W'($urandom);
        dma_set(1'b1, d_we, 16'h0100 + 16'(d_ix), d_wd);
        d_st = 1; d_lat = 0;
      end else if (d_st == 2) begin
        bus.dma_req = 1'b0; d_st = 0;
      end
    end
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    Reset = 1'b1;
    bd_en = 1'b0; bd_addr = '0; bd_data = '0;
    bus.mem_rdata = '0;
    cpu_set(1'b0, 1'b0, '0, '0);
    dma_set(1'b0, 1'b0, '0, '0);
    test_reset();
    test_cpu_read();
    test_dma_write_cpu_read();
    test_contention();
    test_reset_mid();
    test_early_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
